// File: rtl/agc_loop_controller.sv
// Block-averaging automatic gain control loop: averages 2^window magnitude samples,
// compares against a reference and steps an unsigned fixed-point gain by alpha*error.
module agc_loop_controller #(
  parameter int W_MAG       = 16,
  parameter int W_ALPHA     = 16,
  parameter int F_ALPHA     = 14,
  parameter int W_REF       = 16,
  parameter int W_GAIN      = 16,
  parameter int F_GAIN      = 14,
  parameter int LOG2_MAXWIN = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_enable,
  input  logic [3:0]         i_window_log2,
  input  logic [W_ALPHA-1:0] i_alpha,
  input  logic [W_REF-1:0]   i_reference,
  input  logic [W_MAG-1:0]   s_mag_data,
  input  logic               s_mag_valid,
  output logic               s_mag_ready,
  output logic [W_GAIN-1:0]  o_gain,
  output logic               o_gain_valid,
  output logic               o_sat_hi,
  output logic               o_sat_lo,
  output logic               o_busy
);

  localparam int ACC_W   = W_MAG + LOG2_MAXWIN;
  localparam int CNT_W   = LOG2_MAXWIN + 1;
  localparam int ERR_W   = W_REF + 1;
  localparam int PROD_W  = W_ALPHA + 1 + ERR_W;
  localparam int SUM_W   = ((PROD_W > W_GAIN) ? PROD_W : W_GAIN) + 2;
  localparam int WIN_CAP = (LOG2_MAXWIN > 15) ? 15 : LOG2_MAXWIN;

  localparam logic [3:0]        WIN_CAP_L = 4'(WIN_CAP);
  localparam logic [W_GAIN-1:0] GAIN_ONE  = W_GAIN'(1) << F_GAIN;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    CALC  = 2'd2,
    APPLY = 2'd3
  } state_t;

  state_t                    state, state_nxt;
  logic [ACC_W-1:0]          acc;
  logic [CNT_W-1:0]          cnt;
  logic [3:0]                win;
  logic [3:0]                win_next;
  logic [CNT_W-1:0]          last_idx;
  logic                      accept;
  logic                      last_sample;
  logic signed [ERR_W-1:0]   err;
  logic signed [PROD_W-1:0]  prod;
  logic signed [PROD_W-1:0]  delta;
  logic signed [SUM_W-1:0]   sum;
  logic                      sum_neg;
  logic                      sum_ovf;

  assign accept      = s_mag_valid && (state == ACCUM);
  assign win_next    = (i_window_log2 > WIN_CAP_L) ? WIN_CAP_L : i_window_log2;
  assign last_idx    = (CNT_W'(1) << win) - CNT_W'(1);
  assign last_sample = (cnt == last_idx);

  // The sum of 2^win samples shifted right by win always fits back into W_MAG bits.
  assign err  = $signed({1'b0, i_reference}) - $signed({1'b0, W_REF'(acc >> win)});
  assign prod = PROD_W'($signed({1'b0, i_alpha})) * PROD_W'(err);

  assign sum     = SUM_W'($signed({1'b0, o_gain})) + SUM_W'(delta);
  assign sum_neg = sum[SUM_W-1];
  assign sum_ovf = |sum[SUM_W-2:W_GAIN];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block is given a default first, so no path infers a latch.
  always_comb begin
    state_nxt   = state;
    s_mag_ready = 1'b0;
    o_busy      = (state != IDLE);
    case (state)
      IDLE:  if (i_enable) state_nxt = ACCUM;
      ACCUM: begin
        s_mag_ready = 1'b1;
        if (!i_enable)                  state_nxt = IDLE;
        else if (accept && last_sample) state_nxt = CALC;
      end
      CALC:    state_nxt = i_enable ? APPLY : IDLE;
      // An update already computed is always committed, even if enable just dropped.
      APPLY:   state_nxt = i_enable ? ACCUM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc          <= '0;
      cnt          <= '0;
      win          <= '0;
      delta        <= '0;
      o_gain       <= GAIN_ONE;
      o_gain_valid <= 1'b0;
      o_sat_hi     <= 1'b0;
      o_sat_lo     <= 1'b0;
    end else begin
      o_gain_valid <= 1'b0;
      case (state)
        IDLE: begin
          acc <= '0;
          cnt <= '0;
          win <= win_next;
        end
        ACCUM: begin
          if (accept) begin
            acc <= acc + ACC_W'(s_mag_data);
            cnt <= cnt + CNT_W'(1);
          end
        end
        CALC: delta <= prod >>> F_ALPHA;
        APPLY: begin
          if (sum_neg) begin
            o_gain   <= '0;
            o_sat_hi <= 1'b0;
            o_sat_lo <= 1'b1;
          end else if (sum_ovf) begin
            o_gain   <= '1;
            o_sat_hi <= 1'b1;
            o_sat_lo <= 1'b0;
          end else begin
            o_gain   <= sum[W_GAIN-1:0];
            o_sat_hi <= 1'b0;
            o_sat_lo <= 1'b0;
          end
          o_gain_valid <= 1'b1;
          acc          <= '0;
          cnt          <= '0;
          win          <= win_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_agc_loop_controller.sv
// Directed bench for agc_loop_controller: hand-computed gain updates, saturation,
// streaming backpressure, enable aborts and asynchronous reset.
module tb_agc_loop_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_enable;
  logic [3:0]  i_window_log2;
  logic [15:0] i_alpha;
  logic [15:0] i_reference;
  logic [15:0] s_mag_data;
  logic        s_mag_valid;
  logic        s_mag_ready;
  logic [15:0] o_gain;
  logic        o_gain_valid;
  logic        o_sat_hi;
  logic        o_sat_lo;
  logic        o_busy;

  int checks = 0;
  int errors = 0;
  int g_exp  = 16384;

  always #5 clk = ~clk;

  agc_loop_controller #(
    .W_MAG(16), .W_ALPHA(16), .F_ALPHA(14), .W_REF(16),
    .W_GAIN(16), .F_GAIN(14), .LOG2_MAXWIN(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_enable(i_enable),
    .i_window_log2(i_window_log2),
    .i_alpha(i_alpha),
    .i_reference(i_reference),
    .s_mag_data(s_mag_data),
    .s_mag_valid(s_mag_valid),
    .s_mag_ready(s_mag_ready),
    .o_gain(o_gain),
    .o_gain_valid(o_gain_valid),
    .o_sat_hi(o_sat_hi),
    .o_sat_lo(o_sat_lo),
    .o_busy(o_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one sample and returns just after the edge that accepts it.
  task automatic send(input logic [15:0] d);
    int n;
    n = 0;
    s_mag_valid = 1'b1;
    s_mag_data  = d;
    while (!s_mag_ready && n < 20) begin
      tick();
      n++;
    end
    check("ready_wait", s_mag_ready, 1);
    tick();
    s_mag_valid = 1'b0;
  endtask

  // Called just after the edge that accepted the last sample of a window.
  task automatic expect_update(input string tag, input int gain, input bit hi, input bit lo);
    check({tag, "_valid_calc"}, o_gain_valid, 0);
    check({tag, "_ready_calc"}, s_mag_ready, 0);
    tick();
    check({tag, "_valid_apply"}, o_gain_valid, 0);
    check({tag, "_ready_apply"}, s_mag_ready, 0);
    tick();
    check({tag, "_valid"}, o_gain_valid, 1);
    check({tag, "_gain"}, o_gain, gain);
    check({tag, "_sat_hi"}, o_sat_hi, hi);
    check({tag, "_sat_lo"}, o_sat_lo, lo);
    tick();
    check({tag, "_valid_drop"}, o_gain_valid, 0);
  endtask

  task automatic no_pulse(input string tag, input int n);
    int p;
    p = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (o_gain_valid) p++;
    end
    check(tag, p, 0);
  endtask

  // Asserts reset between edges and checks outputs before any edge arrives.
  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    check({tag, "_gain"}, o_gain, 16384);
    check({tag, "_valid"}, o_gain_valid, 0);
    check({tag, "_sat_hi"}, o_sat_hi, 0);
    check({tag, "_sat_lo"}, o_sat_lo, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_ready"}, s_mag_ready, 0);
    s_mag_valid = 1'b0;
    i_enable    = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    g_exp = 16384;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] d [17];
    int   idx, updates, low_run;
    logic rdy;

    reset         = 1'b1;
    i_enable      = 1'b0;
    i_window_log2 = 4'd0;
    i_alpha       = '0;
    i_reference   = '0;
    s_mag_data    = '0;
    s_mag_valid   = 1'b0;
    tick();
    tick();
    check("rst_gain", o_gain, 16384);
    check("rst_valid", o_gain_valid, 0);
    check("rst_sat_hi", o_sat_hi, 0);
    check("rst_sat_lo", o_sat_lo, 0);
    check("rst_busy", o_busy, 0);
    check("rst_ready", s_mag_ready, 0);
    reset = 1'b0;
    tick();
    check("idle_busy", o_busy, 0);

    // Window 4, avg 4096, err 4096, alpha 1.0 -> gain +4096.
    i_window_log2 = 4'd2;
    i_reference   = 16'd8192;
    i_alpha       = 16'd16384;
    i_enable      = 1'b1;
    tick();
    check("accum_busy", o_busy, 1);
    check("accum_ready", s_mag_ready, 1);
    for (int i = 0; i < 4; i++) send(16'd4096);
    expect_update("win4", 20480, 0, 0);

    // Huge positive step clamps at full scale, and stays there.
    i_enable = 1'b0;
    tick();
    check("disable_busy", o_busy, 0);
    i_window_log2 = 4'd0;
    i_reference   = 16'hFFFF;
    i_alpha       = 16'hFFFF;
    i_enable      = 1'b1;
    send(16'd0);
    expect_update("sat_hi", 65535, 1, 0);
    send(16'd0);
    expect_update("sat_hi_rep", 65535, 1, 0);

    // From 1.0, a -65535 step clamps at zero.
    async_reset("rst_a");
    i_window_log2 = 4'd0;
    i_reference   = 16'd0;
    i_alpha       = 16'd16384;
    i_enable      = 1'b1;
    send(16'hFFFF);
    expect_update("sat_lo", 0, 0, 1);

    // Continuous valid, window 2: ready low two cycles per window, exact pairing.
    async_reset("rst_b");
    for (int j = 0; j < 17; j++) d[j] = 16'(1501 + 97 * j);
    i_window_log2 = 4'd1;
    i_reference   = 16'd2000;
    i_alpha       = 16'd16384;
    i_enable      = 1'b1;
    tick();
    check("stream_ready0", s_mag_ready, 1);
    idx         = 0;
    updates     = 0;
    low_run     = 0;
    s_mag_data  = d[0];
    s_mag_valid = 1'b1;
    for (int c = 0; c < 100 && updates < 8; c++) begin
      rdy = s_mag_ready;
      tick();
      if (rdy) begin
        idx++;
        s_mag_data = d[idx];
      end
      if (!s_mag_ready) low_run++;
      else if (low_run != 0) begin
        check("ready_low_run", low_run, 2);
        low_run = 0;
      end
      if (o_gain_valid) begin
        g_exp += 2000 - ((int'(d[2*updates]) + int'(d[2*updates+1])) >> 1);
        updates++;
        check("stream_gain", o_gain, g_exp);
        check("stream_count", idx, 2 * updates);
      end
    end
    s_mag_valid = 1'b0;
    check("stream_updates", updates, 8);

    // Abort after 3 of 4 samples, then a fresh window; mid-window window change deferred.
    i_enable = 1'b0;
    tick();
    i_window_log2 = 4'd2;
    i_reference   = 16'd8192;
    i_alpha       = 16'd16384;
    i_enable      = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) send(16'd4096);
    i_enable = 1'b0;
    tick();
    check("abort_busy", o_busy, 0);
    check("abort_ready", s_mag_ready, 0);
    no_pulse("abort_no_pulse", 4);
    check("abort_gain", o_gain, g_exp);
    i_enable = 1'b1;
    send(16'd4096);
    i_window_log2 = 4'd3;
    for (int i = 0; i < 3; i++) send(16'd4096);
    g_exp += 4096;
    expect_update("refill", g_exp, 0, 0);

    // Enable falling during APPLY still commits the update.
    i_enable = 1'b0;
    tick();
    i_window_log2 = 4'd0;
    i_enable      = 1'b1;
    send(16'd4096);
    tick();
    i_enable = 1'b0;
    tick();
    g_exp += 4096;
    check("apply_fall_valid", o_gain_valid, 1);
    check("apply_fall_gain", o_gain, g_exp);
    check("apply_fall_busy", o_busy, 0);
    tick();
    check("apply_fall_drop", o_gain_valid, 0);

    // Enable falling during CALC discards the update.
    i_enable = 1'b1;
    send(16'd4096);
    i_enable = 1'b0;
    tick();
    check("calc_abort_busy", o_busy, 0);
    no_pulse("calc_abort_no_pulse", 4);
    check("calc_abort_gain", o_gain, g_exp);

    // Reset mid-accumulation.
    i_window_log2 = 4'd2;
    i_enable      = 1'b1;
    send(16'd4096);
    send(16'd4096);
    async_reset("rst_accum");
    i_enable = 1'b1;
    no_pulse("rst_accum_no_pulse", 6);
    check("rst_accum_busy", o_busy, 1);

    // Reset during APPLY.
    i_enable = 1'b0;
    tick();
    i_window_log2 = 4'd0;
    i_reference   = 16'd8192;
    i_alpha       = 16'd16384;
    i_enable      = 1'b1;
    send(16'd4096);
    tick();
    async_reset("rst_apply");
    i_enable = 1'b1;
    no_pulse("rst_apply_no_pulse", 6);
    check("rst_apply_gain", o_gain, 16384);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/agc_loop_controller.md
AGC_LOOP_CONTROLLER -- requirements
Module: agc_loop_controller

Interface
REQ-001 Parameter W_MAG, default 16: width of the unsigned magnitude sample (|I|+|Q|).
REQ-002 Parameter W_ALPHA, default 16; parameter F_ALPHA, default 14: loop-speed width and fraction bits (unsigned).
REQ-003 Parameter W_REF, default 16: reference-level width (unsigned, same scale as magnitude).
REQ-004 Parameter W_GAIN, default 16; parameter F_GAIN, default 14: gain width and fraction bits (unsigned).
REQ-005 Parameter LOG2_MAXWIN, default 8: log2 of the largest averaging window.
REQ-006 clk  input  1  single clock; all logic rising-edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 i_enable  input  1  loop run enable.
REQ-009 i_window_log2  input  4  log2 of window length N.
REQ-010 i_alpha  input  W_ALPHA  loop step size.
REQ-011 i_reference  input  W_REF  target average magnitude.
REQ-012 s_mag_data  input  W_MAG  magnitude sample.
REQ-013 s_mag_valid  input  1  sample valid.
REQ-014 s_mag_ready  output  1  sample accepted when valid&&ready.
REQ-015 o_gain  output  W_GAIN  current gain, unsigned fixed point with F_GAIN fraction bits.
REQ-016 o_gain_valid  output  1  one-cycle pulse on each gain update.
REQ-017 o_sat_hi / o_sat_lo  output  1 each  last update clamped at max / min.
REQ-018 o_busy  output  1  high in any state other than IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, ACCUM, CALC, APPLY; s_mag_ready SHALL be high only in ACCUM.
REQ-020 IDLE->ACCUM on i_enable=1; on entry, the accumulator and sample counter clear, and the window latches as min(i_window_log2, LOG2_MAXWIN).
REQ-021 In ACCUM, each handshake SHALL add s_mag_data to an unsigned accumulator of W_MAG+LOG2_MAXWIN bits (never overflows) and increment the counter.
REQ-022 The edge accepting sample N (N=2^window) SHALL move to CALC; samples offered in CALC/APPLY SHALL be stalled (ready low), not dropped.
REQ-023 CALC edge: avg = acc >> window; err = i_reference - avg as signed W_REF+1 bits; prod = alpha*err signed full width; delta = prod arithmetic-shifted right F_ALPHA (truncate toward -inf); i_alpha and i_reference sampled on this edge.
REQ-024 APPLY edge: o_gain <= clamp(o_gain + delta, 0, 2^W_GAIN-1); o_sat_hi/o_sat_lo set per clamp, held until the next update; o_gain_valid high the following cycle only; state -> ACCUM with counter/accumulator cleared and window re-latched.
REQ-025 Latency: o_gain_valid SHALL be observed exactly 2 cycles after the cycle in which sample N is accepted.
REQ-026 i_enable=0 in any state SHALL return to IDLE at the next edge, discard the partial window, and hold o_gain and flags; no o_gain_valid pulse for an aborted window.
REQ-027 i_enable falling in APPLY SHALL still commit that update (APPLY completes before IDLE).
REQ-028 Changes to i_window_log2 mid-window SHALL take effect only at the next window start.

Reset
REQ-029 On reset: state IDLE, o_gain=2^F_GAIN (1.0), o_gain_valid=0, o_sat_hi=o_sat_lo=0, o_busy=0, s_mag_ready=0, accumulator and counter=0.
REQ-030 Reset asserted mid-window SHALL abandon it immediately; no update is emitted after release.

Verification
REQ-031 Window=2, ref=8192, alpha=16384, 4 samples of 4096 back-to-back -> o_gain 16384->20480, o_gain_valid one pulse 2 cycles after 4th handshake, flags 0.
REQ-032 Window=0, ref=65535, alpha=65535, sample 0 -> o_gain=65535, o_sat_hi=1; repeat -> stays 65535, o_sat_hi=1.
REQ-033 Window=0, ref=0, alpha=16384, sample 65535 from gain 16384 -> o_gain=0, o_sat_lo=1.
REQ-034 s_mag_valid held high continuously, window=1 -> ready low exactly 2 cycles per window; no sample lost or double-counted (sum check over 8 windows).
REQ-035 Deassert i_enable after 3 of 4 samples -> IDLE next edge, gain unchanged, no pulse; re-enable -> fresh 4-sample window.
REQ-036 Assert reset mid-ACCUM and during APPLY -> all outputs at REQ-029 values asynchronously; no o_gain_valid after release.
